// File: rtl/pixel_capture_pkg.sv
// Shared types and constants for the pixel_capture block.
// Included by the top and the FIFO; no logic lives here.
package pixel_capture_pkg;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO. Pushes while full are dropped;
// the full test looks at occupancy before any same-cycle pop.
module capture_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));
    assign level = count_q;
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Head word is gated so the port reads zero whenever nothing is held.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        count_d  = count_q + LW'(wr_ok) - LW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pixel_capture.sv
// Camera capture stage: frame FSM, edge detect, byte packer and FIFO.
// Define PIXEL_CAPTURE_STATS_EN to build the line/word statistics counters.
module pixel_capture
    import pixel_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ARM,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    OVERFLOW,
    input  logic                    CAM_VSYNC,
    input  logic                    CAM_HREF,
    input  logic                    CAM_PIX_VALID,
    input  logic [PIX_W-1:0]        CAM_DATA,
    input  logic                    RD_EN,
    output logic [WORD_W-1:0]       RD_DATA,
    output logic                    RD_EMPTY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic [CNT_W-1:0]        LINE_COUNT,
    output logic [CNT_W-1:0]        WORD_COUNT,
    output logic [1:0]              DBG_STATE
);

    state_e             state_q, state_d;
    logic               cam_vsync_q, cam_href_q, cam_valid_q;
    logic [PIX_W-1:0]   cam_data_q;
    logic               vsync_prev_q, href_prev_q;
    logic               pending_q, pending_d;
    logic [PIX_W-1:0]   hi_q, hi_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               push;
    logic [WORD_W-1:0]  push_word;
    logic               fifo_full;
    logic               clear_cnt, line_inc, stats_latch;
    logic               vsync_fall, vsync_rise, href_fall, byte_ok;

    assign vsync_fall = vsync_prev_q && !cam_vsync_q;
    assign vsync_rise = !vsync_prev_q && cam_vsync_q;
    assign href_fall  = href_prev_q && !cam_href_q;
    assign byte_ok    = (state_q == CAPTURE) && cam_href_q && cam_valid_q;

    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign OVERFLOW  = overflow_q;
    assign DBG_STATE = state_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hi_d        = hi_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        push        = 1'b0;
        push_word   = '0;
        clear_cnt   = 1'b0;
        line_inc    = 1'b0;
        stats_latch = 1'b0;
        case (state_q)
            IDLE: begin
                if (ARM) begin
                    state_d    = ARMED;
                    overflow_d = 1'b0;
                    pending_d  = 1'b0;
                    clear_cnt  = 1'b1;
                end
            end
            ARMED: begin
                if (vsync_fall) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (byte_ok) begin
                    if (!pending_q) begin
                        hi_d      = cam_data_q;
                        pending_d = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_word = {hi_q, cam_data_q};
                        pending_d = 1'b0;
                    end
                end
                // A line ending on an odd byte flushes it padded with zero.
                if (href_fall) begin
                    line_inc  = 1'b1;
                    pending_d = 1'b0;
                    if (pending_q) begin
                        push      = 1'b1;
                        push_word = {hi_q, PIX_W'(0)};
                    end
                end
                if (vsync_rise) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stats_latch = 1'b1;
                    pending_d   = 1'b0;
                    if (pending_q && cam_href_q && !byte_ok) begin
                        push      = 1'b1;
                        push_word = {hi_q, PIX_W'(0)};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (push && fifo_full) overflow_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cam_vsync_q  <= 1'b0;
            cam_href_q   <= 1'b0;
            cam_valid_q  <= 1'b0;
            cam_data_q   <= '0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            pending_q    <= 1'b0;
            hi_q         <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cam_vsync_q  <= CAM_VSYNC;
            cam_href_q   <= CAM_HREF;
            cam_valid_q  <= CAM_PIX_VALID;
            cam_data_q   <= CAM_DATA;
            vsync_prev_q <= cam_vsync_q;
            href_prev_q  <= cam_href_q;
            pending_q    <= pending_d;
            hi_q         <= hi_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

`ifdef PIXEL_CAPTURE_STATS_EN
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] line_count_q, line_count_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    always_comb begin
        line_cnt_d   = line_cnt_q;
        word_cnt_d   = word_cnt_q;
        line_count_d = line_count_q;
        word_count_d = word_count_q;
        if (clear_cnt) begin
            line_cnt_d = '0;
            word_cnt_d = '0;
        end else begin
            if (line_inc)            line_cnt_d = line_cnt_q + CNT_W'(1);
            if (push && !fifo_full)  word_cnt_d = word_cnt_q + CNT_W'(1);
        end
        // Latch includes any increment from the frame-ending cycle itself.
        if (stats_latch) begin
            line_count_d = line_cnt_d;
            word_count_d = word_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            line_cnt_q   <= '0;
            word_cnt_q   <= '0;
            line_count_q <= '0;
            word_count_q <= '0;
        end else begin
            line_cnt_q   <= line_cnt_d;
            word_cnt_q   <= word_cnt_d;
            line_count_q <= line_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign LINE_COUNT = line_count_q;
    assign WORD_COUNT = word_count_q;
`else
    logic unused_stats;
    assign unused_stats = ^{clear_cnt, line_inc, stats_latch};
    assign LINE_COUNT   = '0;
    assign WORD_COUNT   = '0;
`endif

    capture_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (RD_EN),
        .rd_data (RD_DATA),
        .empty   (RD_EMPTY),
        .full    (fifo_full),
        .level   (LEVEL)
    );

endmodule

// File: tb/tb_pixel_capture.sv
// Directed bench for pixel_capture: framing, packing, padding, overflow,
// simultaneous push/pop and mid-frame reset.
module tb_pixel_capture;
    import pixel_capture_pkg::*;

`ifdef PIXEL_CAPTURE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    arm;
    logic                    busy, done, overflow;
    logic                    cam_vsync, cam_href, cam_pix_valid;
    logic [7:0]              cam_data;
    logic                    rd_en;
    logic [15:0]             rd_data;
    logic                    rd_empty;
    logic [$clog2(DEPTH):0]  level;
    logic [CNT_W-1:0]        line_count, word_count;
    logic [1:0]              dbg_state;

    pixel_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .ARM           (arm),
        .BUSY          (busy),
        .DONE          (done),
        .OVERFLOW      (overflow),
        .CAM_VSYNC     (cam_vsync),
        .CAM_HREF      (cam_href),
        .CAM_PIX_VALID (cam_pix_valid),
        .CAM_DATA      (cam_data),
        .RD_EN         (rd_en),
        .RD_DATA       (rd_data),
        .RD_EMPTY      (rd_empty),
        .LEVEL         (level),
        .LINE_COUNT    (line_count),
        .WORD_COUNT    (word_count),
        .DBG_STATE     (dbg_state)
    );

    // scoreboard
    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks (inputs change on negedge, outputs sampled on negedge)
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
        chk("state_armed", dbg_state, ARMED);
    endtask

    task automatic frame_start();
        cam_vsync = 1'b0;
        cyc(2);
    endtask

    task automatic send_line(input int n, input logic [7:0] base);
        cam_href = 1'b1;
        for (int i = 0; i < n; i++) begin
            cam_pix_valid = 1'b1;
            cam_data      = 8'(base + 8'(i));
            @(negedge clk);
        end
        cam_pix_valid = 1'b0;
        cam_href      = 1'b0;
        cyc(2);
    endtask

    task automatic frame_end_check();
        cam_vsync = 1'b1;
        @(negedge clk);
        chk("busy_before_end", busy, 1);
        chk("done_early", done, 0);
        @(negedge clk);
        chk("busy_after_end", busy, 0);
        chk("done_pulse", done, 1);
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            chk("drain_empty", rd_empty, 0);
            chk("drain_data", rd_data, exp_q.pop_front());
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        chk("drain_final_empty", rd_empty, 1);
        chk("drain_final_level", level, 0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; rd_en = 1'b0;
        cam_vsync = 1'b1; cam_href = 1'b0; cam_pix_valid = 1'b0; cam_data = 8'h00;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_level", level, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_line_count", line_count, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        cyc(3);

        // basic frame: 2 lines x 4 bytes
        arm_pulse();
        frame_start();
        chk("state_capture", dbg_state, CAPTURE);
        send_line(4, 8'h01);
        send_line(4, 8'h05);
        frame_end_check();
        chk("basic_level", level, 4);
        chk("basic_lines", line_count, STATS ? 2 : 0);
        chk("basic_words", word_count, STATS ? 4 : 0);
        exp_q.push_back(16'h0102); exp_q.push_back(16'h0304);
        exp_q.push_back(16'h0506); exp_q.push_back(16'h0708);
        drain();
        cyc(2);
        chk("basic_done_count", done_cnt, 1);

        // odd line with latency check, then a 2-byte line
        arm_pulse();
        frame_start();
        cam_href = 1'b1; cam_pix_valid = 1'b1; cam_data = 8'hAA;
        @(negedge clk);
        cam_data = 8'hBB;
        @(negedge clk);
        chk("lat_not_yet", rd_empty, 1);
        cam_data = 8'hCC;
        @(negedge clk);
        chk("lat_visible", rd_empty, 0);
        chk("lat_data", rd_data, 16'hAABB);
        cam_pix_valid = 1'b0; cam_href = 1'b0;
        cyc(3);
        chk("odd_level_pad", level, 2);
        send_line(2, 8'h11);
        frame_end_check();
        chk("odd_lines", line_count, STATS ? 2 : 0);
        chk("odd_words", word_count, STATS ? 3 : 0);
        exp_q.push_back(16'hAABB); exp_q.push_back(16'hCC00); exp_q.push_back(16'h1112);
        drain();

        // arm while VSYNC already low: that frame is skipped
        cam_vsync = 1'b0;
        cyc(3);
        arm_pulse();
        send_line(2, 8'h55);
        cam_vsync = 1'b1;
        cyc(3);
        chk("midarm_busy", busy, 1);
        chk("midarm_state", dbg_state, ARMED);
        chk("midarm_level", level, 0);
        chk("midarm_done_count", done_cnt, 2);
        frame_start();
        send_line(2, 8'h77);
        frame_end_check();
        exp_q.push_back(16'h7778);
        drain();

        // overflow: 20 words into a 16-deep FIFO
        arm_pulse();
        frame_start();
        send_line(40, 8'h40);
        frame_end_check();
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_lines", line_count, STATS ? 1 : 0);
        chk("ovf_words", word_count, STATS ? 16 : 0);
        for (int j = 0; j < 16; j++) exp_q.push_back({8'(8'h40 + 2 * j), 8'(8'h41 + 2 * j)});
        drain();
        chk("ovf_sticky", overflow, 1);
        arm_pulse();
        chk("ovf_cleared", overflow, 0);

        // simultaneous push/pop at level 5, then push-when-full with pop
        frame_start();
        send_line(10, 8'h10);
        exp_q.push_back(16'h1011); exp_q.push_back(16'h1213); exp_q.push_back(16'h1415);
        exp_q.push_back(16'h1617); exp_q.push_back(16'h1819);
        chk("pp_level_before", level, 5);
        cam_href = 1'b1; cam_pix_valid = 1'b1; cam_data = 8'h20;
        @(negedge clk);
        cam_data = 8'h21;
        @(negedge clk);
        chk("pp_head", rd_data, exp_q.pop_front());
        cam_pix_valid = 1'b0; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pp_level_same", level, 5);
        exp_q.push_back(16'h2021);
        cam_href = 1'b0;
        cyc(2);
        send_line(22, 8'h30);
        for (int j = 0; j < 11; j++) exp_q.push_back({8'(8'h30 + 2 * j), 8'(8'h31 + 2 * j)});
        chk("pp_level_full", level, 16);
        chk("pp_no_overflow_yet", overflow, 0);
        cam_href = 1'b1; cam_pix_valid = 1'b1; cam_data = 8'h50;
        @(negedge clk);
        cam_data = 8'h51;
        @(negedge clk);
        chk("full_head", rd_data, exp_q.pop_front());
        cam_pix_valid = 1'b0; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("full_pop_level", level, 15);
        chk("full_drop_overflow", overflow, 1);
        cam_href = 1'b0;
        cyc(2);
        frame_end_check();
        chk("pp_lines", line_count, STATS ? 4 : 0);
        chk("pp_words", word_count, STATS ? 17 : 0);
        drain();
        chk("pp_done_count", done_cnt, 5);

        // reset in the middle of a frame
        arm_pulse();
        frame_start();
        cam_href = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cam_pix_valid = 1'b1;
            cam_data = 8'(8'h60 + 8'(i));
            @(negedge clk);
        end
        cam_pix_valid = 1'b0;
        cyc(2);
        chk("rstmid_level", level, 2);
        chk("rstmid_busy", busy, 1);
        rst = 1'b1; cam_href = 1'b0; cam_vsync = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("rstmid_busy_after", busy, 0);
        chk("rstmid_empty", rd_empty, 1);
        chk("rstmid_level_after", level, 0);
        chk("rstmid_done", done, 0);
        cyc(3);
        chk("rstmid_no_done", done_cnt, 5);
        arm_pulse();
        frame_start();
        send_line(2, 8'h9A);
        frame_end_check();
        chk("rearm_level", level, 1);
        chk("rearm_lines", line_count, STATS ? 1 : 0);
        chk("rearm_words", word_count, STATS ? 1 : 0);
        exp_q.push_back(16'h9A9B);
        drain();
        cyc(2);
        chk("final_done_count", done_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_capture.md
# pixel_capture

Fabric-side camera capture stage clocked from the MSS fabric clock, sitting directly upstream of the `mss_capture` MSS interface. It samples an 8-bit parallel camera bus, frames it on VSYNC/HREF, packs byte pairs into 16-bit words and buffers them in a small synchronous FIFO. The MSS drains the FIFO through a first-word-fall-through read port. Capture is armed one frame at a time.

## Interface
- `DEPTH`, 16: FIFO depth in 16-bit words; power of two, at least 4.
- `CNT_W`, 16: width of the statistics counters.

Clocking and reset:
- `CLK` in 1 — fabric clock (FAB_CLK). Single clock domain; reset is synchronous and active-high.
- `RESET` in 1 — synchronous reset, active-high.

Control and status:
- `ARM` in 1 — single-cycle pulse that arms capture of the next full frame.
- `BUSY` out 1 — high while armed or capturing.
- `DONE` out 1 — one-cycle pulse at frame end.
- `OVERFLOW` out 1 — sticky flag: a word was dropped because the FIFO was full.

Camera inputs (already synchronised to `CLK`):
- `CAM_VSYNC` in 1 — high between frames.
- `CAM_HREF` in 1 — high during active line.
- `CAM_PIX_VALID` in 1 — byte strobe, one cycle per byte.
- `CAM_DATA` in 8 — pixel byte.

Read port and statistics:
- `RD_EN` in 1 — pop the head word.
- `RD_DATA` out 16 — head word, valid when `RD_EMPTY` is low.
- `RD_EMPTY` out 1 — FIFO empty.
- `LEVEL` out clog2(`DEPTH`)+1 — FIFO occupancy.
- `LINE_COUNT` out `CNT_W` — lines in the last completed frame.
- `WORD_COUNT` out `CNT_W` — words pushed in the last completed frame.

## Operation
- State machine:
  - IDLE → ARMED on `ARM`. Entering ARMED clears `OVERFLOW` and the working counters.
  - ARMED → CAPTURE on a VSYNC falling edge.
  - CAPTURE → IDLE on a VSYNC rising edge; `DONE` pulses and the statistics latch.
- `ARM` is ignored while in ARMED or CAPTURE.
- Edges are detected against registered previous values. The previous VSYNC and HREF registers reset to 0, so a VSYNC that is already low after reset produces no falling edge.
- A byte is accepted only in CAPTURE, on a cycle with `CAM_HREF` and `CAM_PIX_VALID` both high.
  - The first byte of a pair goes to [15:8] and the second to [7:0]; the word is pushed on the second byte.
- On an HREF falling edge with an odd byte pending, the pending byte is pushed with [7:0]=0x00.
  - The pair phase resets at every HREF falling edge, so a new line always starts on the high byte.
  - The line counter increments on each HREF falling edge in CAPTURE.
- A VSYNC rising edge with a byte pending and HREF still high pads and pushes as above in the same cycle, then exits.
- Push when full: the word is dropped and `OVERFLOW` is set. The full test uses occupancy before any same-cycle pop.
- `WORD_COUNT` counts accepted pushes only; dropped words are not counted.
- `RD_EN` when empty is ignored. Push and pop in the same cycle when not full leaves `LEVEL` unchanged.
- FIFO read and write pointers wrap modulo `DEPTH`. `LEVEL` ranges 0..`DEPTH`.
- The FIFO is not flushed on `ARM`; the MSS drains leftover words.

## Timing
- Reset values:
  - `BUSY`=0, `DONE`=0, `OVERFLOW`=0.
  - `RD_EMPTY`=1, `LEVEL`=0, `RD_DATA`=0.
  - Counters=0, state IDLE.
- `BUSY` rises the cycle after `ARM` and falls the cycle after the VSYNC rising edge is detected. `DONE` is high in that same cycle.
- Camera input to registered edge detect takes 1 cycle. A second byte sampled at cycle N is visible at `RD_DATA` with `RD_EMPTY` low at N+2.
- A pop at cycle N presents the next word, or asserts `RD_EMPTY`, at N+1.
- `RESET` mid-frame aborts capture, returns to IDLE and empties the FIFO. No `DONE` pulse is generated.

## Configuration
- `PIXEL_CAPTURE_STATS_EN` defined: the line and word counters are built. `LINE_COUNT` and `WORD_COUNT` latch at frame end and hold until the next frame end.
- Not defined: the counters are omitted and `LINE_COUNT`/`WORD_COUNT` are tied to 0. All other behaviour is identical.

## Structure
- Package `pixel_capture_pkg` holds:
  - the state enum (IDLE, ARMED, CAPTURE);
  - constants `PIX_W`=8 and `WORD_W`=16.
- Sub-module `capture_fifo`: a synchronous FWFT FIFO parameterised by `DEPTH` and width. It owns `LEVEL`, the empty and full flags, and drop-on-full behaviour.
- `pixel_capture` holds the FSM, edge detect, byte packer and counters.

## Test plan
- Basic frame: ARM, then a frame of 2 lines × 4 bytes 0x01..0x08 → words 0x0102, 0x0304, 0x0506, 0x0708; `DONE` pulses once; `LINE_COUNT`=2, `WORD_COUNT`=4.
- Odd line: a line of 3 bytes 0xAA, 0xBB, 0xCC → words 0xAABB, 0xCC00; the next line starts on the high byte.
- Mid-frame arm: ARM while VSYNC is already low → no capture until the next VSYNC fall/rise cycle; the following full frame is captured.
- Overflow: `DEPTH`=16, push 20 words with no reads → `LEVEL`=16, `OVERFLOW`=1, `WORD_COUNT`=16. The next ARM clears `OVERFLOW`.
- Simultaneous push/pop: at `LEVEL`=5, `RD_EN` in the same cycle as a push → `LEVEL` stays 5 and the order is preserved. Push when full with a same-cycle pop → word dropped.
- Reset mid-frame: assert `RESET` during CAPTURE → `BUSY`=0, `RD_EMPTY`=1, no `DONE`; ARM works normally afterwards.
